trade_order_sequencer: RTL and testbench

Order sequencer between the trading-logic unit's registered `buy_signal`/`sell_signal` outputs and the downstream order-entry interface. It turns a buy or sell decision into a single outstanding order on a valid/ready handshake. It then waits for a fill acknowledgement or timeout, tracks the net signed position against a limit, and enforces a cooldown before the next decision is accepted.

---
 rtl/trade_order_sequencer.sv | 133 +++++++++++++
 tb/tb_trade_order_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/trade_order_sequencer.sv
// trade_order_sequencer
// Turns a buy/sell decision into one outstanding order on a valid/ready
// handshake. It then waits for a fill ack or a timeout, tracks the signed net
// position against +/-MAX_POS, and holds off new decisions for a cooldown.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | accepting decisions (enable, one-hot buy/sell, limit ok)
// S_ISSUE    | order_valid high, waiting for order_ready
// S_WAIT_ACK | order accepted downstream, waiting for ack or timeout
// S_COOLDOWN | order finished, ignoring decisions for the cooldown
module trade_order_sequencer #(
  parameter logic [7:0]  QTY             = 8'd1,
  parameter logic [7:0]  MAX_POS         = 8'd4,
  parameter logic [15:0] COOLDOWN_CYCLES = 16'd16,
  parameter logic [15:0] ACK_TIMEOUT     = 16'd64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       buy_signal,
  input  logic       sell_signal,
  input  logic [7:0] price,
  output logic       order_valid,
  input  logic       order_ready,
  output logic       order_side,
  output logic [7:0] order_qty,
  output logic [7:0] order_price,
  input  logic       ack_valid,
  input  logic       ack_filled,
  output logic [7:0] position,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_COOLDOWN} state_t;

  state_t      state, state_nxt;
  logic [15:0] to_cnt, to_cnt_nxt;
  logic [15:0] cd_cnt, cd_cnt_nxt;
  logic        order_valid_nxt, order_side_nxt, busy_nxt, timeout_err_nxt;
  logic [7:0]  order_qty_nxt, order_price_nxt, position_nxt;

  // 9-bit signed views so the limit checks cannot wrap
  logic signed [8:0] pos_ext, qty_ext, max_ext;
  logic              buy_ok, sell_ok, to_term;

  assign pos_ext = {position[7], position};
  assign qty_ext = {1'b0, QTY};
  assign max_ext = {1'b0, MAX_POS};
  assign buy_ok  = enable && buy_signal && !sell_signal && ((pos_ext + qty_ext) <= max_ext);
  assign sell_ok = enable && sell_signal && !buy_signal && ((pos_ext - qty_ext) >= -max_ext);
  assign to_term = (to_cnt == (ACK_TIMEOUT - 16'd1));

  // State, counters and every output are registered here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      to_cnt      <= 16'd0;
      cd_cnt      <= 16'd0;
      order_valid <= 1'b0;
      order_side  <= 1'b0;
      order_qty   <= 8'd0;
      order_price <= 8'd0;
      position    <= 8'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      to_cnt      <= to_cnt_nxt;
      cd_cnt      <= cd_cnt_nxt;
      order_valid <= order_valid_nxt;
      order_side  <= order_side_nxt;
      order_qty   <= order_qty_nxt;
      order_price <= order_price_nxt;
      position    <= position_nxt;
      busy        <= busy_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

  // Next-state selection; an ack on the terminal timeout cycle takes precedence
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (buy_ok || sell_ok)     state_nxt = S_ISSUE;
      S_ISSUE:    if (order_ready)           state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: if (ack_valid || to_term)  state_nxt = S_COOLDOWN;
      S_COOLDOWN: if (cd_cnt <= 16'd1)       state_nxt = S_IDLE;
      default:                               state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs, order fields and counters
  always_comb begin
    to_cnt_nxt      = to_cnt;
    cd_cnt_nxt      = cd_cnt;
    order_side_nxt  = order_side;
    order_price_nxt = order_price;
    position_nxt    = position;
    timeout_err_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (buy_ok) begin
          order_side_nxt  = 1'b0;
          order_price_nxt = price;
        end else if (sell_ok) begin
          order_side_nxt  = 1'b1;
          order_price_nxt = price;
        end
      end
      S_ISSUE: to_cnt_nxt = 16'd0;
      S_WAIT_ACK: begin
        to_cnt_nxt = to_cnt + 16'd1;
        if (ack_valid) begin
          cd_cnt_nxt = COOLDOWN_CYCLES;
          if (ack_filled)
            position_nxt = order_side ? (position - QTY) : (position + QTY);
        end else if (to_term) begin
          cd_cnt_nxt      = COOLDOWN_CYCLES;
          timeout_err_nxt = 1'b1;
        end
      end
      // A load of 0 or 1 both give a single cooldown cycle
      S_COOLDOWN: cd_cnt_nxt = (cd_cnt > 16'd1) ? (cd_cnt - 16'd1) : 16'd0;
      default: ;
    endcase
    order_valid_nxt = (state_nxt == S_ISSUE);
    order_qty_nxt   = (state_nxt == S_ISSUE) ? QTY : 8'd0;
    busy_nxt        = (state_nxt != S_IDLE);
  end

endmodule

// File: tb/tb_trade_order_sequencer.sv
// Directed bench for trade_order_sequencer with default parameters
// (QTY=1, MAX_POS=4, COOLDOWN_CYCLES=16, ACK_TIMEOUT=64).
module tb_trade_order_sequencer;

  logic       clk, rst_n, enable, buy_signal, sell_signal;
  logic [7:0] price;
  logic       order_valid, order_ready, order_side;
  logic [7:0] order_qty, order_price;
  logic       ack_valid, ack_filled;
  logic [7:0] position;
  logic       busy, timeout_err;

  int errors = 0;
  int checks = 0;

  trade_order_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .buy_signal  (buy_signal),
    .sell_signal (sell_signal),
    .price       (price),
    .order_valid (order_valid),
    .order_ready (order_ready),
    .order_side  (order_side),
    .order_qty   (order_qty),
    .order_price (order_price),
    .ack_valid   (ack_valid),
    .ack_filled  (ack_filled),
    .position    (position),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    chk("wait_idle", 16'(busy), 16'd0);
  endtask

  // Full order with ready high: decision, handshake, ack, cooldown
  task automatic order(input logic sell, input logic filled);
    buy_signal  = !sell;
    sell_signal = sell;
    tick();
    buy_signal  = 1'b0;
    sell_signal = 1'b0;
    tick();
    ack_valid  = 1'b1;
    ack_filled = filled;
    tick();
    ack_valid  = 1'b0;
    ack_filled = 1'b0;
    wait_idle();
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; buy_signal = 1'b0; sell_signal = 1'b0;
    price = 8'd0; order_ready = 1'b0; ack_valid = 1'b0; ack_filled = 1'b0;
    #1;
    chk("rst_valid", 16'(order_valid), 16'd0);
    chk("rst_pos",   16'(position),    16'd0);
    chk("rst_busy",  16'(busy),        16'd0);
    chk("rst_qty",   16'(order_qty),   16'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Basic buy at price 100
    order_ready = 1'b1;
    price       = 8'd100;
    buy_signal  = 1'b1;
    tick();
    buy_signal = 1'b0;
    chk("buy_valid", 16'(order_valid), 16'd1);
    chk("buy_busy",  16'(busy),        16'd1);
    chk("buy_side",  16'(order_side),  16'd0);
    chk("buy_qty",   16'(order_qty),   16'd1);
    chk("buy_price", 16'(order_price), 16'd100);
    tick();
    chk("hs_valid", 16'(order_valid), 16'd0);
    chk("hs_qty",   16'(order_qty),   16'd0);
    tick(); tick();
    ack_valid = 1'b1; ack_filled = 1'b1;
    tick();
    ack_valid = 1'b0; ack_filled = 1'b0;
    chk("fill_pos",  16'(position),    16'd1);
    chk("fill_busy", 16'(busy),        16'd1);
    chk("fill_terr", 16'(timeout_err), 16'd0);
    // Signals and acks during cooldown are dropped
    sell_signal = 1'b1; ack_valid = 1'b1; ack_filled = 1'b1;
    tick();
    sell_signal = 1'b0; ack_valid = 1'b0; ack_filled = 1'b0;
    repeat (14) tick();
    chk("cd_busy15", 16'(busy), 16'd1);
    tick();
    chk("cd_busy16", 16'(busy),     16'd0);
    chk("cd_pos",    16'(position), 16'd1);
    tick();
    chk("cd_drop", 16'(busy), 16'd0);

    // Backpressure on a sell at price 50, then a rejected ack
    order_ready = 1'b0;
    price       = 8'd50;
    sell_signal = 1'b1;
    tick();
    sell_signal = 1'b0;
    price       = 8'd77;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 16'(order_valid), 16'd1);
      chk("bp_side",  16'(order_side),  16'd1);
      chk("bp_price", 16'(order_price), 16'd50);
      tick();
    end
    chk("bp_hold", 16'(order_valid), 16'd1);
    order_ready = 1'b1;
    tick();
    chk("bp_done", 16'(order_valid), 16'd0);
    ack_valid = 1'b1; ack_filled = 1'b0;
    tick();
    ack_valid = 1'b0;
    chk("rej_pos",  16'(position), 16'd1);
    chk("rej_busy", 16'(busy),     16'd1);
    wait_idle();

    // Conflict and enable low
    buy_signal = 1'b1; sell_signal = 1'b1;
    tick();
    chk("conflict", 16'(busy), 16'd0);
    sell_signal = 1'b0; enable = 1'b0;
    tick();
    chk("disabled", 16'(busy), 16'd0);
    buy_signal = 1'b0; enable = 1'b1;

    // Long limit: 1 -> 4, further buy blocked, sell accepted
    for (int i = 0; i < 3; i++) order(1'b0, 1'b1);
    chk("pos_max", 16'(position), 16'd4);
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    chk("max_block", 16'(busy), 16'd0);
    order(1'b1, 1'b1);
    chk("pos_3", 16'(position), 16'd3);

    // Short limit: 3 -> -4, further sell blocked, buy accepted
    for (int i = 0; i < 7; i++) order(1'b1, 1'b1);
    chk("pos_min", 16'(position), 16'h00FC);
    sell_signal = 1'b1;
    tick();
    sell_signal = 1'b0;
    chk("min_block", 16'(busy), 16'd0);
    order(1'b0, 1'b1);
    chk("pos_m3", 16'(position), 16'h00FD);

    // Timeout with no ack
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    tick();
    repeat (63) tick();
    chk("to_early", 16'(timeout_err), 16'd0);
    chk("to_busy",  16'(busy),        16'd1);
    tick();
    chk("to_pulse", 16'(timeout_err), 16'd1);
    chk("to_pos",   16'(position),    16'h00FD);
    tick();
    chk("to_end", 16'(timeout_err), 16'd0);
    wait_idle();

    // Ack on the terminal timeout cycle wins
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    tick();
    repeat (63) tick();
    ack_valid = 1'b1; ack_filled = 1'b1;
    tick();
    ack_valid = 1'b0; ack_filled = 1'b0;
    chk("late_terr", 16'(timeout_err), 16'd0);
    chk("late_pos",  16'(position),    16'h00FE);
    tick();
    chk("late_terr2", 16'(timeout_err), 16'd0);
    wait_idle();

    // Reset in the middle of WAIT_ACK
    buy_signal = 1'b1;
    tick();
    buy_signal = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",  16'(busy),        16'd0);
    chk("mid_rst_pos",   16'(position),    16'd0);
    chk("mid_rst_valid", 16'(order_valid), 16'd0);
    chk("mid_rst_price", 16'(order_price), 16'd0);
    repeat (3) tick();
    chk("mid_rst_terr", 16'(timeout_err), 16'd0);
    rst_n = 1'b1;
    tick();
    order(1'b0, 1'b1);
    chk("post_rst_pos", 16'(position), 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
